led_jasnosc_sterownik: RTL
==========================

# led_jasnosc_sterownik

Button-driven brightness controller for the board LED. It debounces two push-buttons (brightness up/down), keeps a saturating brightness level of 0–3, and ramps the PWM duty toward that level's threshold, one step per PWM period. It drives a PWM generator sub-module that produces `out_led`. It sits between the raw board buttons and the LED pin, on the 10 MHz board clock.

## Interface
- `CNT_W`, 16 — PWM counter width; the PWM period is 2^CNT_W cycles (153 Hz at 10 MHz).
- `DEBOUNCE_CYCLES`, 100000 — number of stable cycles needed to accept a button level (10 ms).
- `FADE_STEP`, 256 — duty change applied per PWM period while fading.

- `in_clk` in 1 — system clock; everything is single clock domain.
- `in_rst_n` in 1 — reset, asynchronous, active-low.
- `in_przycisk_plus` in 1 — brightness-up button; active-high; asynchronous to `in_clk`.
- `in_przycisk_minus` in 1 — brightness-down button; active-high; asynchronous to `in_clk`.
- `out_led` out 1 — PWM output to the LED.
- `out_poziom` out 2 — current target level: 0 = 10 %, 1 ≈ 21.5 %, 2 ≈ 46.4 %, 3 = 100 %.
- `out_zajety` out 1 — high while the applied duty differs from the target duty.

## Operation
**Synchronizer and debouncer**
- Each button passes through a 2-FF synchronizer.
- A per-button counter tracks the synchronized level.
- The debounced state takes the new level only after the level has been stable for `DEBOUNCE_CYCLES` consecutive cycles.
- Any change in the synchronized level restarts the counter.
- A rising edge of the debounced state produces a one-cycle press event.

**Level register**
- A press event on plus increments `out_poziom`; a press event on minus decrements it.
- The level saturates at 3 and at 0; it never wraps.
- Plus and minus events in the same cycle are both ignored.

**Target duty**
- The target is `THR[out_poziom]` from the shared package, with width `CNT_W+1`.
- `THR[n] = floor(2^CNT_W · 0.1 · 10^(n/3))` for n = 0..2, and `THR[3] = 2^CNT_W`.

**Applied duty (`duty`)**
- `duty` is updated only on the cycle where the PWM counter equals all-ones, so each new duty takes effect from the next period.
- If `duty < target`: `duty` becomes min(duty + FADE_STEP, target).
- If `duty > target`: `duty` becomes max(duty − FADE_STEP, target).
- Arithmetic is done at width `CNT_W+2` to avoid overflow or underflow.
- A level change during a fade retargets the fade; the ramp continues from the current `duty`.

**PWM output**
- The counter is free-running, `CNT_W` bits wide, and wraps to 0.
- `out_led` is registered: `out_led <= (cnt < duty)`.
- When `duty = 2^CNT_W`, `out_led` is constant 1.

**Combined output**
- `out_zajety = (duty != target)`.

## Timing
**Reset values**
- Counter: 0.
- `duty`: `THR[0]`.
- `out_poziom`: 0.
- `out_led`: 0.
- `out_zajety`: 0.
- Debounced states: 0.
- Synchronizers: 0.

**Behaviour after release**
- The first PWM period starts at counter 0; `out_led` goes high on the first clock after release.
- Asserting reset mid-fade or mid-debounce immediately restores all reset values.

**Latencies**
- Button edge to press event: 2 + `DEBOUNCE_CYCLES` cycles (±1 cycle of synchronizer skew).
- Press event to `out_poziom` update: 1 cycle.
- `out_zajety` rises in the same cycle as `out_poziom` changes, when the target differs from `duty`.
- The first duty change lands at the next period boundary.
- A full fade takes ceil(|Δ| / FADE_STEP) periods.
- `out_led` lags the compare by 1 cycle.

**Boundary conditions**
- Button releases and bounce shorter than `DEBOUNCE_CYCLES` produce no event.
- A button held continuously produces exactly one event.

## Configuration
- **`LED_FADE_EN` defined:** the ramping behaviour described above.
- **`LED_FADE_EN` not defined:**
  - `duty` loads the target directly at the next period boundary.
  - `out_zajety` is high from the level change until that boundary.
  - `FADE_STEP` is unused.

## Structure
- **Package `led_pkg`:**
  - Function `prog_jasnosci(n, cnt_w)` returning `THR[n]`.
  - Typedef `poziom_t` (logic [1:0]).
  - Constants `POZIOM_MIN = 0` and `POZIOM_MAX = 3`.
- **Sub-module `led_pwm_gen`:** contains the counter, the period-boundary strobe output and the registered compare. It is instantiated once.
- **Debouncing:** implemented as a generate loop over both buttons inside the top module; it is not a separate module.

## Test plan
All tests use `CNT_W=8`, `DEBOUNCE_CYCLES=4`, `FADE_STEP=16`. The thresholds are then 25 / 55 / 118 / 256.

1. **Reset:** hold reset, then release → `out_led` is 0 during reset, then high for 25 cycles of every 256-cycle period; `out_poziom` = 0 and `out_zajety` = 0.
2. **Single plus press with fade:** press plus and hold for 10 cycles → `out_poziom` = 1; `duty` goes 41 then 55 on two consecutive boundaries; `out_zajety` drops after the second boundary. With `LED_FADE_EN` undefined → `duty` goes to 55 in one boundary.
3. **Bounce rejection:** 3-cycle pulses separated by 2-cycle gaps on minus → no press event; `out_poziom` unchanged.
4. **Saturation:** five clean plus presses → `out_poziom` = 3; after the ramp settles, `out_led` is constant 1. Then five minus presses → `out_poziom` = 0; `duty` settles at 25.
5. **Simultaneous presses:** plus and minus edges applied in the same cycle at level 1 → no level change; `out_zajety` stays 0.
6. **Reset mid-fade:** assert reset during a 25→118 ramp → `duty` = 25, `out_poziom` = 0, `out_led` = 0 immediately; normal 25-cycle PWM after release.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and brightness thresholds for the LED brightness controller.
// prog_jasnosci(n, cnt_w) gives the PWM duty threshold of level n.
package led_pkg;

  typedef logic [1:0] poziom_t;

  localparam poziom_t POZIOM_MIN = 2'd0;
  localparam poziom_t POZIOM_MAX = 2'd3;

  // floor(2^cnt_w * 0.1 * 10^(n/3)), factors scaled by 1e9;
  // level 3 is the full period (LED constantly on).
  function automatic logic [31:0] prog_jasnosci(
    input int n,
    input int cnt_w
  );
    logic [63:0] pelny;
    logic [63:0] k;
    pelny = 64'd1 << cnt_w;
    k = 64'd0;
    case (n)
      0: k = 64'd100000000;
      1: k = 64'd215443469;
      2: k = 64'd464158883;
      default: return pelny[31:0];
    endcase
    return 32'((pelny * k) / 64'd1000000000);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// PWM generator: free-running counter, period-end strobe, registered compare.
// Ports: in_clk, in_rst_n, in_duty (CNT_W+1 b), out_led, out_koniec.
module led_pwm_gen #(
  parameter int CNT_W = 16
) (
  input  logic           in_clk,
  input  logic           in_rst_n,
  input  logic [CNT_W:0] in_duty,
  output logic           out_led,
  output logic           out_koniec
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cnt     <= '0;
      out_led <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      out_led <= ({1'b0, cnt} < in_duty);
    end
  end

  // High on the last count; a duty loaded here applies from count 0.
  assign out_koniec = &cnt;

endmodule

// File: rtl/led_jasnosc_sterownik.sv
// Button brightness controller: debounce, 0..3 level, duty ramp, PWM.
// Ports: in_clk, in_rst_n, in_przycisk_plus/minus, out_led, out_poziom,
// out_zajety. Macro LED_FADE_EN enables gradual duty ramping.
module led_jasnosc_sterownik
  import led_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int FADE_STEP       = 256
) (
  input  logic    in_clk,
  input  logic    in_rst_n,
  input  logic    in_przycisk_plus,
  input  logic    in_przycisk_minus,
  output logic    out_led,
  output poziom_t out_poziom,
  output logic    out_zajety
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W:0] THR0 = (CNT_W+1)'(prog_jasnosci(0, CNT_W));
  localparam logic [CNT_W:0] THR1 = (CNT_W+1)'(prog_jasnosci(1, CNT_W));
  localparam logic [CNT_W:0] THR2 = (CNT_W+1)'(prog_jasnosci(2, CNT_W));
  localparam logic [CNT_W:0] THR3 = (CNT_W+1)'(prog_jasnosci(3, CNT_W));

`ifdef LED_FADE_EN
  localparam int KROK = FADE_STEP;
`else
  // A step covering the whole duty range makes every update snap
  // straight onto the target.
  localparam int KROK = (FADE_STEP > 2 ** (CNT_W + 1)) ?
                        FADE_STEP : 2 ** (CNT_W + 1);
`endif

  localparam logic [CNT_W+1:0] STEP = (CNT_W+2)'(KROK);

  logic [1:0] przyciski;
  logic [1:0] zdarzenie;

  assign przyciski = {in_przycisk_minus, in_przycisk_plus};

  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [1:0]      sync;
    logic [DB_W-1:0] licz;
    logic            stan;
    logic            stan_q;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
        sync   <= '0;
        licz   <= '0;
        stan   <= 1'b0;
        stan_q <= 1'b0;
      end else begin
        sync   <= {sync[0], przyciski[i]};
        stan_q <= stan;
        if (sync[1] == stan) begin
          licz <= '0;
        end else if (licz == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stan <= sync[1];
          licz <= '0;
        end else begin
          licz <= licz + 1'b1;
        end
      end
    end

    assign zdarzenie[i] = stan & ~stan_q;
  end

  logic    tylko_plus;
  logic    tylko_minus;
  poziom_t poziom;

  assign tylko_plus  = zdarzenie[0] & ~zdarzenie[1];
  assign tylko_minus = zdarzenie[1] & ~zdarzenie[0];

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      poziom <= POZIOM_MIN;
    end else begin
      unique case (1'b1)
        tylko_plus && (poziom != POZIOM_MAX):
          poziom <= poziom + 2'd1;
        tylko_minus && (poziom != POZIOM_MIN):
          poziom <= poziom - 2'd1;
        default: ;
      endcase
    end
  end

  logic [CNT_W:0] cel;

  always_comb begin
    cel = THR0;
    unique case (poziom)
      2'd0: cel = THR0;
      2'd1: cel = THR1;
      2'd2: cel = THR2;
      2'd3: cel = THR3;
    endcase
  end

  logic [CNT_W:0]   duty;
  logic [CNT_W:0]   duty_nast;
  logic [CNT_W+1:0] d_ext;
  logic [CNT_W+1:0] c_ext;
  logic [CNT_W+1:0] w_gore;
  logic [CNT_W+1:0] w_dol;
  logic             koniec;

  assign d_ext  = {1'b0, duty};
  assign c_ext  = {1'b0, cel};
  assign w_gore = d_ext + STEP;
  assign w_dol  = d_ext - STEP;

  always_comb begin
    duty_nast = duty;
    if (duty < cel) begin
      duty_nast = (w_gore > c_ext) ? cel : w_gore[CNT_W:0];
    end else if (duty > cel) begin
      duty_nast = (d_ext < c_ext + STEP) ? cel : w_dol[CNT_W:0];
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      duty <= THR0;
    end else if (koniec) begin
      duty <= duty_nast;
    end
  end

  led_pwm_gen #(
    .CNT_W(CNT_W)
  ) u_pwm (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .in_duty   (duty),
    .out_led   (out_led),
    .out_koniec(koniec)
  );

  assign out_poziom = poziom;
  assign out_zajety = (duty != cel);

endmodule
